// File: rtl/writeback_unit.sv
// writeback_unit: final pipeline stage. It merges ALU results and formatted
// load results onto the single register-file write port. Loads are held in
// a small FIFO, both sources share the port round-robin, and writes to x0
// are dropped without being counted.
module writeback_unit #(
  parameter int LD_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_alu_valid,
  input  logic [4:0]  i_alu_rd,
  input  logic [31:0] i_alu_val,
  output logic        o_alu_ready,
  input  logic        i_ld_valid,
  input  logic [4:0]  i_ld_rd,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic [31:0] i_ld_data,
  output logic        o_ld_ready,
  output logic [4:0]  o_w_reg_num,
  output logic [31:0] o_w_val,
  output logic        o_op,
  output logic        o_err,
  output logic [31:0] o_wb_count
);

  // Source that won the most recent grant; the other one wins a tie.
  typedef enum logic {SRC_ALU = 1'b0, SRC_LOAD = 1'b1} src_t;

  // FIFO entry layout: {rd[41:37], funct3[36:34], addr_lo[33:32], data[31:0]}
  localparam int ENTRY_W = 42;
  localparam logic [1:0] DEPTH_C = 2'(LD_DEPTH);

  logic [ENTRY_W-1:0] fifo_mem [LD_DEPTH];
  logic               wr_ptr_reg;
  logic               rd_ptr_reg;
  logic [1:0]         count_reg;
  logic [1:0]         count_next;
  src_t               rr_last_reg;
  src_t               rr_last_next;

  logic               op_reg;
  logic [4:0]         w_reg_num_reg;
  logic [31:0]        w_val_reg;
  logic               err_reg;
  logic [31:0]        wb_count_reg;

  logic               enq;
  logic               deq;
  logic               alu_cand;
  logic               ld_cand;
  logic               grant_alu;
  logic               grant_ld;

  logic [ENTRY_W-1:0] head;
  logic [4:0]         head_rd;
  logic [2:0]         head_funct3;
  logic [1:0]         head_lo;
  logic [31:0]        head_data;
  logic [7:0]         head_byte [4];
  logic [15:0]        head_half;
  logic [7:0]         sel_byte;
  logic [31:0]        fmt_val;
  logic               fmt_err;

  logic               wr_fire;
  logic [4:0]         wr_rd;
  logic [31:0]        wr_val;
  logic               err_fire;

  assign head        = fifo_mem[rd_ptr_reg];
  assign head_rd     = head[41:37];
  assign head_funct3 = head[36:34];
  assign head_lo     = head[33:32];
  assign head_data   = head[31:0];

  // Split the head word into byte lanes so the lane mux reads plainly.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign head_byte[gi] = head_data[8*gi +: 8];
  end

  assign sel_byte  = head_byte[head_lo];
  assign head_half = head_lo[1] ? head_data[31:16] : head_data[15:0];

  // No pass-through: a full FIFO refuses new loads even if it drains now.
  assign o_ld_ready  = (count_reg < DEPTH_C);
  // The ALU is only refused when a load is waiting and it is the load's turn.
  assign o_alu_ready = (count_reg == 2'd0) || (rr_last_reg == SRC_LOAD);

  assign enq = i_ld_valid && o_ld_ready;
  assign deq = grant_ld;

  // Round-robin between ALU and FIFO head; a lone candidate always wins.
  always_comb begin
    alu_cand     = i_alu_valid;
    ld_cand      = (count_reg != 2'd0);
    grant_alu    = alu_cand && (!ld_cand || (rr_last_reg == SRC_LOAD));
    grant_ld     = ld_cand && (!alu_cand || (rr_last_reg == SRC_ALU));
    rr_last_next = rr_last_reg;
    if (grant_alu) begin
      rr_last_next = SRC_ALU;
    end else if (grant_ld) begin
      rr_last_next = SRC_LOAD;
    end
  end

  // Align and extend the head load; flag unsupported or misaligned forms.
  always_comb begin
    fmt_val = '0;
    fmt_err = 1'b0;
    unique case (head_funct3)
      3'b000:  fmt_val = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  fmt_val = {24'b0, sel_byte};
      3'b001: begin
        fmt_val = {{16{head_half[15]}}, head_half};
        fmt_err = head_lo[0];
      end
      3'b101: begin
        fmt_val = {16'b0, head_half};
        fmt_err = head_lo[0];
      end
      3'b010: begin
        fmt_val = head_data;
        fmt_err = (head_lo != 2'b00);
      end
      default: fmt_err = 1'b1;
    endcase
  end

  // Decide what, if anything, goes to the register file this cycle.
  always_comb begin
    wr_fire  = 1'b0;
    wr_rd    = '0;
    wr_val   = '0;
    err_fire = 1'b0;
    if (grant_alu) begin
      wr_fire = (i_alu_rd != 5'd0);
      wr_rd   = i_alu_rd;
      wr_val  = i_alu_val;
    end else if (grant_ld) begin
      err_fire = fmt_err;
      wr_fire  = !fmt_err && (head_rd != 5'd0);
      wr_rd    = head_rd;
      wr_val   = fmt_val;
    end
  end

  // Occupancy: simultaneous enqueue and dequeue leave it unchanged.
  always_comb begin
    count_next = count_reg + 2'(enq) - 2'(deq);
  end

  // Load storage; contents need no reset since count gates visibility.
  always_ff @(posedge i_clk) begin
    if (enq) begin
      fifo_mem[wr_ptr_reg] <= {i_ld_rd, i_ld_funct3, i_ld_addr_lo, i_ld_data};
    end
  end

  // FIFO pointers, occupancy and arbitration history.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_reg  <= 1'b0;
      rd_ptr_reg  <= 1'b0;
      count_reg   <= 2'd0;
      rr_last_reg <= SRC_LOAD;
    end else begin
      if (enq) wr_ptr_reg <= ~wr_ptr_reg;
      if (deq) rd_ptr_reg <= ~rd_ptr_reg;
      count_reg   <= count_next;
      rr_last_reg <= rr_last_next;
    end
  end

  // Registered write port: every field lasts exactly one cycle per grant.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      op_reg        <= 1'b0;
      w_reg_num_reg <= '0;
      w_val_reg     <= '0;
      err_reg       <= 1'b0;
      wb_count_reg  <= '0;
    end else begin
      op_reg        <= wr_fire;
      w_reg_num_reg <= wr_fire ? wr_rd : 5'd0;
      w_val_reg     <= wr_fire ? wr_val : 32'd0;
      err_reg       <= err_fire;
      if (wr_fire) wb_count_reg <= wb_count_reg + 32'd1;
    end
  end

  assign o_op        = op_reg;
  assign o_w_reg_num = w_reg_num_reg;
  assign o_w_val     = w_val_reg;
  assign o_err       = err_reg;
  assign o_wb_count  = wb_count_reg;

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Final pipeline stage of the RISC-V core: collects completed results from the ALU and the load unit, aligns and sign/zero-extends load data, and arbitrates both sources onto the single register-file write port (`i_w_reg_num`, `i_w_val`, `i_op`). It buffers up to two load results, alternates fairly between sources when both are pending, and discards writes to x0. It also flags illegal or misaligned loads and counts retired writes.

## Interface
- LD_DEPTH, 2, load result FIFO depth in entries; fixed at 2, no other value supported
- i_clk  in  1  clock, all state updates on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_alu_valid  in  1  ALU result present
- i_alu_rd  in  5  ALU destination register
- i_alu_val  in  32  ALU result
- o_alu_ready  out  1  ALU result accepted this cycle when high with i_alu_valid
- i_ld_valid  in  1  load result present
- i_ld_rd  in  5  load destination register
- i_ld_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- i_ld_addr_lo  in  2  byte offset of load address
- i_ld_data  in  32  raw aligned memory word
- o_ld_ready  out  1  load result accepted when high with i_ld_valid
- o_w_reg_num  out  5  to register file i_w_reg_num
- o_w_val  out  32  to register file i_w_val
- o_op  out  1  to register file i_op; 1 = write this cycle, 0 = read/idle
- o_err  out  1  one-cycle pulse: illegal funct3 or misaligned load dropped
- o_wb_count  out  32  number of register writes issued, wraps at 2^32

## Operation
- Load FIFO: 2 entries storing {rd, funct3, addr_lo, data}. Enqueue on i_ld_valid && o_ld_ready; o_ld_ready = (count < 2), no pass-through when full.
- Arbiter candidates per cycle: ALU (i_alu_valid) and FIFO head (count > 0). Single candidate wins. Both present: source not granted last (rr_last) wins; rr_last updates on every grant.
- o_alu_ready = (count == 0) || (rr_last == LOAD); combinational, independent of i_alu_valid.
- FIFO head dequeued when granted; enqueue and dequeue in the same cycle leave count unchanged.
- Load formatting, byte lane = addr_lo: LB/LBU select data[8*lane+7:8*lane], sign/zero extend; LH/LHU select the halfword at lane 0 or 2, sign/zero extend; LW passes the whole word.
- Error cases: funct3 in {011,110,111}; LH/LHU with addr_lo odd; LW with addr_lo != 0. The entry is consumed, o_op stays 0, and o_err pulses 1.
- rd == 0 (either source): entry consumed, o_op stays 0, counter unchanged, no error.
- Valid non-x0 grant: registered o_op=1, o_w_reg_num=rd, o_w_val=value; o_wb_count increments.

## Timing
- Reset values:
  - o_op 0, o_w_reg_num 0, o_w_val 0, o_err 0, o_wb_count 0
  - FIFO count 0, rr_last = LOAD (ALU favoured first)
  - o_ld_ready 1, o_alu_ready 1
- Reset mid-operation: FIFO contents and in-flight output are discarded; o_op is 0 in the cycle after i_rst is sampled high.
- ALU latency: accepted at edge N, grant is combinational in cycle N, so o_op=1 during cycle N+1.
- Load latency: enqueued at edge N, head visible in cycle N+1, o_op=1 during cycle N+2 if granted; each lost arbitration adds 1 cycle.
- o_op, o_err, and the data outputs hold for exactly one cycle per grant; o_op returns to 0 when there is no grant.
- At most one register write per cycle.
- With continuous traffic on both sources, grants alternate strictly ALU, LOAD, ALU, ...
- o_err and o_op are never both 1 in the same cycle.
- Register file consumes o_op/o_w_* as the write; its read path (i_op=0) is available every cycle o_op=0.

## Test plan
- After reset: ALU rd=5, val=0x12345678 accepted -> next cycle o_op=1, o_w_reg_num=5, o_w_val=0x12345678, o_wb_count=1; cycle after, o_op=0.
- Loads with data=0x80FF7F01, rd=9:
  - LB lane 3 -> 0xFFFFFF80
  - LBU lane 3 -> 0x00000080
  - LH lane 2 -> 0xFFFF80FF
  - LHU lane 0 -> 0x00007F01
  - LW lane 0 -> 0x80FF7F01
  - each written 2 cycles after accept.
- Hold both valid for 6 cycles (loads rd=1..3, ALU rd=10..12) -> writes alternate ALU, LOAD; o_ld_ready drops when FIFO holds 2; no entry lost or duplicated.
- LW addr_lo=2, then funct3=111 -> each dropped with a one-cycle o_err pulse and o_op=0; o_wb_count unchanged; next valid load is written normally.
- ALU rd=0 val=0xDEADBEEF -> o_alu_ready high, o_op stays 0, o_err 0, count unchanged.
- Fill FIFO with 2 loads, assert i_rst one cycle -> o_op=0, FIFO empty, o_ld_ready=1, o_wb_count=0; no stale load written afterwards.
